// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared op codes, FSM states and constants for the data RAM port
package data_mem_ctrl_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8,
    OP_LL  = 4'd9,
    OP_SC  = 4'd10
  } op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_e;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam int BYTE_W = 8;
  // Encodings 11..15 are reserved and behave as NOP.
  function automatic logic is_mem_op(input logic [3:0] op);
    return op >= OP_LB && op <= OP_SC;
  endfunction
  function automatic logic is_load(input logic [3:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW || op == OP_LL;
  endfunction
  function automatic logic is_store(input logic [3:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW || op == OP_SC;
  endfunction
endpackage

// File: rtl/data_mem_ctrl_mem_lane_align.sv
// mem_lane_align: big-endian byte-lane steering, load extension and alignment check
//   op, off     : access op and byte offset addr[1:0]
//   wdata       : right-justified store data -> wlane (replicated into every lane position)
//   rword       : raw RAM read word -> rext (aligned and sign/zero-extended)
//   sel         : byte-lane select, misaligned : alignment violation for op/off
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  sel,
  output logic [31:0] wlane,
  output logic [31:0] rext,
  output logic        misaligned
);
  logic byte_op, half_op, word_op;
  logic [31:0] rsh;
  logic [BYTE_W-1:0] rbyte;
  logic [2*BYTE_W-1:0] rhalf;
  always_comb begin
    byte_op = op == OP_LB || op == OP_LBU || op == OP_SB;
    half_op = op == OP_LH || op == OP_LHU || op == OP_SH;
    word_op = op == OP_LW || op == OP_LL || op == OP_SW || op == OP_SC;
    // offset 0 is the most significant lane, so shift down by (3-off) bytes
    rsh = rword >> (BYTE_W * (3 - int'(off)));
    rbyte = rsh[BYTE_W-1:0];
    rhalf = off[1] ? rword[15:0] : rword[31:16];
    sel = byte_op ? (4'b1000 >> off) : half_op ? (off[1] ? 4'b0011 : 4'b1100) : word_op ? 4'b1111 : 4'b0000;
    wlane = byte_op ? {4{wdata[7:0]}} : half_op ? {2{wdata[15:0]}} : word_op ? wdata : ZERO_WORD;
    rext = op == OP_LB  ? {{24{rbyte[7]}}, rbyte} :
           op == OP_LBU ? {24'd0, rbyte} :
           op == OP_LH  ? {{16{rhalf[15]}}, rhalf} :
           op == OP_LHU ? {16'd0, rhalf} :
           (op == OP_LW || op == OP_LL) ? rword : ZERO_WORD;
    misaligned = (half_op && off[0]) || (word_op && off != 2'b00);
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage initiator for the byte-lane data RAM with wait states and LL/SC link bit
//   clk, rst                 : clock, asynchronous active-high reset
//   req_i, op_i, addr_i, wdata_i, ll_clear_i : pipeline request side
//   stall_o, done_o, rdata_o, exc_adel_o, exc_ades_o, llbit_o : pipeline response side
//   mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o, mem_data_i : RAM port
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              ll_clear_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              exc_adel_o,
  output logic              exc_ades_o,
  output logic              llbit_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i
);
  state_e state;
  logic [3:0] op_q, cnt, lane_op, sel;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, lane_wdata, wlane, rext;
  logic [1:0] lane_off;
  logic active, last, misaligned;
  // In IDLE the aligner checks the incoming request; during the access it steers the captured one.
  always_comb begin
    active = state == ST_ACCESS || state == ST_WAIT;
    last = active && cnt == 4'd0;
    lane_op = active ? op_q : op_i;
    lane_off = active ? addr_q[1:0] : addr_i[1:0];
    lane_wdata = active ? wdata_q : wdata_i;
  end
  mem_lane_align u_align (
    .op         (lane_op),
    .off        (lane_off),
    .wdata      (lane_wdata),
    .rword      (mem_data_i),
    .sel        (sel),
    .wlane      (wlane),
    .rext       (rext),
    .misaligned (misaligned)
  );
  // RAM strobes decode straight from state so an asynchronous reset kills them at once.
  always_comb begin
    mem_ce_o = active ? CHIP_ENABLE : CHIP_DISABLE;
    mem_we_o = last && is_store(op_q);
    mem_addr_o = active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_sel_o = active ? sel : 4'b0000;
    mem_data_o = active && is_store(op_q) ? wlane : ZERO_WORD;
    done_o = state == ST_DONE;
    stall_o = !rst && (state == ST_IDLE ? req_i && is_mem_op(op_i) : active);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q <= OP_NOP;
      addr_q <= '0;
      wdata_q <= ZERO_WORD;
      cnt <= 4'd0;
      rdata_o <= ZERO_WORD;
      exc_adel_o <= FALSE;
      exc_ades_o <= FALSE;
      llbit_o <= FALSE;
    end else begin
      case (state)
        ST_IDLE: if (req_i && is_mem_op(op_i)) begin
          op_q <= op_i;
          addr_q <= addr_i;
          wdata_q <= wdata_i;
          if (misaligned) begin
            state <= ST_DONE;
            exc_adel_o <= is_load(op_i);
            exc_ades_o <= !is_load(op_i);
          end else if (op_i == OP_SC && !llbit_o) state <= ST_DONE;
          else begin
            cnt <= 4'(WAIT_CYCLES);
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS, ST_WAIT: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
          state <= ST_WAIT;
        end else begin
          state <= ST_DONE;
          rdata_o <= op_q == OP_SC ? 32'd1 : is_load(op_q) ? rext : ZERO_WORD;
        end
        default: begin
          state <= ST_IDLE;
          rdata_o <= ZERO_WORD;
          exc_adel_o <= FALSE;
          exc_ades_o <= FALSE;
        end
      endcase
      // an external clear beats a simultaneous LL completion
      if (ll_clear_i) llbit_o <= FALSE;
      else if (last && op_q == OP_LL) llbit_o <= TRUE;
      else if (last && op_q == OP_SC) llbit_o <= FALSE;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl at 0 and 3 wait states
module tb_data_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1, req0 = 1'b0, req3 = 1'b0, ll_clear = 1'b0;
  logic [3:0] op = 4'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic stall0, done0, adel0, ades0, llbit0, ce0, we0;
  logic stall3, done3, adel3, ades3, llbit3, ce3, we3;
  logic [31:0] rdata0, maddr0, mdata0, min0, rdata3, maddr3, mdata3, min3;
  logic [3:0] sel0, sel3;
  logic [31:0] ram0 [0:63];
  logic [31:0] ram3 [0:63];
  int checks = 0, failures = 0;
  int r_cyc, r_ce, r_we, r_st, r_weat;
  logic [31:0] r_rdata, r_dat;
  logic [3:0] r_sel;
  logic r_adel, r_ades, r_stall_done;
  always #5 clk = ~clk;
  data_mem_ctrl #(.WAIT_CYCLES(0), .ADDR_W(32)) u0 (
    .clk(clk), .rst(rst), .req_i(req0), .op_i(op), .addr_i(addr), .wdata_i(wdata), .ll_clear_i(ll_clear),
    .stall_o(stall0), .done_o(done0), .rdata_o(rdata0), .exc_adel_o(adel0), .exc_ades_o(ades0), .llbit_o(llbit0),
    .mem_ce_o(ce0), .mem_we_o(we0), .mem_addr_o(maddr0), .mem_sel_o(sel0), .mem_data_o(mdata0), .mem_data_i(min0));
  data_mem_ctrl #(.WAIT_CYCLES(3), .ADDR_W(32)) u3 (
    .clk(clk), .rst(rst), .req_i(req3), .op_i(op), .addr_i(addr), .wdata_i(wdata), .ll_clear_i(ll_clear),
    .stall_o(stall3), .done_o(done3), .rdata_o(rdata3), .exc_adel_o(adel3), .exc_ades_o(ades3), .llbit_o(llbit3),
    .mem_ce_o(ce3), .mem_we_o(we3), .mem_addr_o(maddr3), .mem_sel_o(sel3), .mem_data_o(mdata3), .mem_data_i(min3));
  assign min0 = ram0[maddr0[7:2]];
  assign min3 = ram3[maddr3[7:2]];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ce0 && we0 && sel0[i]) ram0[maddr0[7:2]][8*i +: 8] <= mdata0[8*i +: 8];
      if (ce3 && we3 && sel3[i]) ram3[maddr3[7:2]][8*i +: 8] <= mdata3[8*i +: 8];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  // Issues one request at posedge+1, holds it until done_o, then lets the DUT return to IDLE.
  task automatic run(input bit w3, input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
    op = o; addr = a; wdata = d;
    if (w3) req3 = 1'b1; else req0 = 1'b1;
    r_cyc = 0; r_ce = 0; r_we = 0; r_st = 0; r_weat = 0; r_sel = '0; r_dat = '0;
    while (r_cyc < 40) begin
      @(posedge clk); #2;
      r_cyc++;
      if (w3 ? done3 : done0) break;
      if (w3 ? stall3 : stall0) r_st++;
      if (w3 ? ce3 : ce0) begin
        r_ce++;
        r_sel = w3 ? sel3 : sel0;
        r_dat = w3 ? mdata3 : mdata0;
      end
      if (w3 ? we3 : we0) begin
        r_we++;
        r_weat = r_cyc;
      end
    end
    r_rdata = w3 ? rdata3 : rdata0;
    r_adel = w3 ? adel3 : adel0;
    r_ades = w3 ? ades3 : ades0;
    r_stall_done = w3 ? stall3 : stall0;
    req0 = 1'b0; req3 = 1'b0; op = 4'd0;
    @(posedge clk); #1;
  endtask
  initial begin
    #12;
    check("reset_ctrl", {31'd0, stall0} | {done0, ce0, we0, llbit0, adel0, ades0}, 32'd0);
    check("reset_bus", rdata0 | maddr0 | mdata0 | {28'd0, sel0}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    run(0, 4'd6, 32'h12, 32'h0000_00AB);
    check("sb_cycles", r_cyc, 2);
    check("sb_ce_cnt", r_ce, 1);
    check("sb_we_cnt", r_we, 1);
    check("sb_sel", {28'd0, r_sel}, 32'b0010);
    check("sb_data", r_dat, 32'hABAB_ABAB);
    run(0, 4'd2, 32'h12, 32'h0);
    check("lbu_data", r_rdata, 32'h0000_00AB);
    run(0, 4'd1, 32'h12, 32'h0);
    check("lb_data", r_rdata, 32'hFFFF_FFAB);
    run(0, 4'd8, 32'h0, 32'h8001_7F00);
    check("sw_ram", ram0[0], 32'h8001_7F00);
    run(0, 4'd3, 32'h0, 32'h0);
    check("lh0_data", r_rdata, 32'hFFFF_8001);
    run(0, 4'd4, 32'h0, 32'h0);
    check("lhu0_data", r_rdata, 32'h0000_8001);
    run(0, 4'd3, 32'h2, 32'h0);
    check("lh2_data", r_rdata, 32'h0000_7F00);
    run(0, 4'd5, 32'h5, 32'h0);
    check("lw_mis_cycles", r_cyc, 1);
    check("lw_mis_exc", {30'd0, r_adel, r_ades}, 32'b10);
    check("lw_mis_ce", r_ce, 0);
    run(0, 4'd7, 32'h3, 32'h1234);
    check("sh_mis_cycles", r_cyc, 1);
    check("sh_mis_exc", {30'd0, r_adel, r_ades}, 32'b01);
    check("sh_mis_we", r_we, 0);
    run(0, 4'd10, 32'h40, 32'h1111_2222);
    check("sc_nolink_rdata", r_rdata, 32'd0);
    check("sc_nolink_cycles", r_cyc, 1);
    check("sc_nolink_we", r_we, 0);
    run(0, 4'd9, 32'h40, 32'h0);
    check("ll_cycles", r_cyc, 2);
    check("ll_llbit", {31'd0, llbit0}, 32'd1);
    run(0, 4'd10, 32'h40, 32'hDEAD_BEEF);
    check("sc_ok_rdata", r_rdata, 32'd1);
    check("sc_ok_we", r_we, 1);
    check("sc_ok_ram", ram0[16], 32'hDEAD_BEEF);
    check("sc_ok_llbit", {31'd0, llbit0}, 32'd0);
    run(0, 4'd9, 32'h40, 32'h0);
    ll_clear = 1'b1;
    @(posedge clk); #1; ll_clear = 1'b0;
    check("llclr_llbit", {31'd0, llbit0}, 32'd0);
    run(0, 4'd10, 32'h40, 32'h0BAD_0BAD);
    check("sc_clr_rdata", r_rdata, 32'd0);
    check("sc_clr_ram", ram0[16], 32'hDEAD_BEEF);
    run(0, 4'd5, 32'h40, 32'h0);
    check("lw_data", r_rdata, 32'hDEAD_BEEF);
    op = 4'd12; req0 = 1'b1; #1;
    check("nop_stall", {31'd0, stall0}, 32'd0);
    @(posedge clk); #2;
    check("nop_ce", {31'd0, ce0}, 32'd0);
    req0 = 1'b0; op = 4'd0;
    @(posedge clk); #1;
    run(1, 4'd8, 32'h20, 32'h1111_1111);
    check("w3_cycles", r_cyc, 5);
    check("w3_stall_cnt", r_st, 4);
    check("w3_we_cnt", r_we, 1);
    check("w3_we_last", r_weat, 4);
    check("w3_done_stall", {31'd0, r_stall_done}, 32'd0);
    check("w3_ram", ram3[8], 32'h1111_1111);
    op = 4'd8; addr = 32'h20; wdata = 32'h5555_5555; req3 = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("rst_pre_ce", {31'd0, ce3}, 32'd1);
    rst = 1'b1; #1;
    check("rst_ctrl", {26'd0, stall3, done3, ce3, we3, adel3, ades3}, 32'd0);
    check("rst_bus", rdata3 | maddr3 | mdata3 | {28'd0, sel3} | {31'd0, llbit3}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    req3 = 1'b0; rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_ram", ram3[8], 32'h1111_1111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Initiator side of the data RAM port, sitting between the MEM pipeline stage and the byte-lane data RAM.
- Accepts one load/store request at a time from the pipeline and drives the RAM ce/we/addr/sel/data_in signals.
- Aligns and sign- or zero-extends returned load data, and raises address-error exceptions.
- Holds the LL/SC link bit.
- Inserts a programmable number of wait states and stalls the pipeline until the access completes.

Parameters:
- WAIT_CYCLES, 0: extra cycles the access is held on the RAM port before data is sampled or the write commits (0..15).
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_i  in  1  pipeline request valid; held by the pipeline while stall_o=1.
- op_i  in  4  0=NOP 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW 9=LL 10=SC; others are treated as NOP.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data, right-justified.
- ll_clear_i  in  1  clears the link bit (exception/ERET).
- stall_o  out  1  pipeline stall.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  load result or SC result; valid while done_o=1.
- exc_adel_o  out  1  load address error; valid with done_o.
- exc_ades_o  out  1  store address error; valid with done_o.
- llbit_o  out  1  current link bit.
- mem_ce_o  out  1  RAM chip enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  ADDR_W  RAM address; bits [1:0] are forced to 0.
- mem_sel_o  out  4  byte-lane select.
- mem_data_o  out  32  RAM write data, lane-positioned.
- mem_data_i  in  32  RAM read data (combinational read).

Behaviour:
- Reset:
  - Reset is asynchronous and active-high, with a single clock (clk).
  - While rst=1, all outputs are 0, state is IDLE, llbit=0 and the wait counter is 0.
  - Reset in mid-access drops mem_ce_o and mem_we_o immediately, because the RAM outputs decode from state.
- Byte order is big-endian:
  - addr[1:0]=0 selects lane 3 (sel 1000, bits 31:24); addr[1:0]=3 selects sel 0001.
  - Halfword at addr[1]=0 uses sel 1100; at addr[1]=1 uses sel 0011.
  - Word accesses use sel 1111.
  - Stores replicate the byte/halfword into every lane position.
- Alignment:
  - LH, LHU, SH require addr[0]=0.
  - LW, LL, SW, SC require addr[1:0]=0.
- FSM states are IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - req_i=1 with a NOP op: ignored.
  - req_i=1 with a misaligned address: capture, go to DONE, and set exc_adel (loads, LL) or exc_ades (stores, SC). No mem_ce_o, llbit unchanged.
  - req_i=1 with SC while llbit=0: go to DONE, rdata=0, no write.
  - Any other valid op: capture op, addr and wdata, load counter=WAIT_CYCLES, go to ACCESS.
  - stall_o = req_i & (op is non-NOP).
- ACCESS / WAIT:
  - mem_ce_o=1, with addr, sel and data driven from the captured values.
  - If counter≠0: decrement and stay (WAIT). Otherwise go to DONE.
  - mem_we_o=1 only in the final cycle (counter=0) for stores, so exactly one write edge occurs.
  - Loads register the extended mem_data_i in the final cycle.
  - stall_o=1.
- DONE:
  - done_o=1, stall_o=0, mem_ce_o=0; always go to IDLE next. req_i in DONE is not sampled.
  - LB/LH results are sign-extended; LBU/LHU are zero-extended.
  - An SC that wrote returns rdata_o=1 and clears llbit.
- Latency: a valid access takes 2+WAIT_CYCLES cycles from accept to done_o. Exception or failed SC takes 1 cycle.
- Link bit:
  - Set on LL completion.
  - Cleared on successful SC, on ll_clear_i, or on reset.
  - If ll_clear_i coincides with an LL completion, clear wins.
  - If ll_clear_i arrives during an SC access, the SC still completes; the bit was sampled at accept.

Decomposition:
- Shared defines/package:
  - op_i encodings.
  - Chip enable/disable and true/false constants.
  - Zero-word constant.
  - Byte-width constant.
- One combinational sub-module, mem_lane_align, covering:
  - op plus addr[1:0] to sel and lane-positioned write data;
  - op plus addr[1:0] plus raw read word to extended load data;
  - misalignment flag.
- The FSM, counter and link bit stay in data_mem_ctrl.

Test Plan:
- SB wdata=0x000000AB at addr 0x12 with WAIT_CYCLES=0. Required: sel=0010 and mem_data=0xABABABAB on one cycle, then done 2 cycles after accept. A following LBU at 0x12 returns 0x000000AB; LB returns 0xFFFFFFAB.
- RAM word 0x8001_7F00. LH at 0x0 returns 0xFFFF8001; LHU at 0x0 returns 0x00008001; LH at 0x2 returns 0x00007F00.
- LW at 0x5 returns done after 1 cycle with exc_adel=1 and no mem_ce. SH at 0x3 gives exc_ades=1 and no mem_we.
- SC at 0x40 with no prior LL returns rdata=0 with no write. LL 0x40 then SC 0x40 with 0xDEADBEEF returns rdata=1, RAM holds 0xDEADBEEF, llbit=0. LL, then ll_clear_i, then SC returns 0.
- WAIT_CYCLES=3, SW: stall_o is high for 4 cycles, mem_we_o is high only in the last of them, done_o comes on cycle 5.
- Assert rst during WAIT of a SW: mem_we_o drops the same cycle, RAM is unchanged, and all outputs are 0.
